// File: rtl/main_memory.sv
// main_memory: backing-store responder on the server side of the memory
// request port. It accepts one load/store at a time, services it after a
// fixed LATENCY and pulses req_fulfilled for one cycle.
// Optional build macro MAIN_MEMORY_MISALIGN_TRAP_EN adds the req_misaligned
// output. Under that macro, misaligned stores are dropped and misaligned
// loads return 0. Without it, misaligned accesses are aligned down to
// their natural container.

package main_memory_pkg;
  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } memory_operation_e;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } memory_operation_size_e;
endpackage

module main_memory
  import main_memory_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [XLEN-1:0]        req_address,
  input  memory_operation_e      req_operation,
  input  memory_operation_size_e req_size,
  input  logic [XLEN-1:0]        req_store_word,
  input  logic                   req_valid,
  output logic [XLEN-1:0]        req_loaded_word,
`ifdef MAIN_MEMORY_MISALIGN_TRAP_EN
  output logic                   req_misaligned,
`endif
  output logic                   req_fulfilled
);

  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int LANES = XLEN / 8;

`ifdef MAIN_MEMORY_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                 state, state_next;
  logic [7:0]             cnt;

  // Latched request; only the address bits that select word and lane are kept.
  logic [AW+1:0]          addr_q;
  memory_operation_e      op_q;
  memory_operation_size_e size_q;
  logic [XLEN-1:0]        wdata_q;

  logic [XLEN-1:0]        mem [DEPTH_WORDS];

  // Access operands: live inputs when jumping straight from IDLE (LATENCY==1),
  // the latched copy otherwise.
  logic [AW+1:0]          acc_addr;
  memory_operation_e      acc_op;
  memory_operation_size_e acc_size;
  logic [XLEN-1:0]        acc_wdata;

  logic                   access;
  logic                   mis;
  logic [1:0]             lane;
  logic [AW-1:0]          idx;
  logic [LANES-1:0]       be;
  logic [XLEN-1:0]        wdata_sh;
  logic [XLEN-1:0]        rdata;
  logic [XLEN-1:0]        rdata_sh;
  logic [XLEN-1:0]        rdata_fmt;
  logic                   write_en;
  logic [XLEN-1:0]        load_result;

  // Upper address bits wrap the space modulo the array size and are ignored.
  logic                   unused_addr_hi;
  assign unused_addr_hi = ^req_address[XLEN-1:AW+2];

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic: IDLE accepts, WAIT counts down, RESP lasts one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req_valid) state_next = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt == 8'd1) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latency counter, loaded on acceptance and decremented while waiting.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= 8'd0;
    end else begin
      case (state)
        IDLE:    if (req_valid) cnt <= 8'(LATENCY - 1);
        WAIT:    cnt <= cnt - 8'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Capture the request when it is accepted; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      addr_q  <= req_address[AW+1:0];
      op_q    <= req_operation;
      size_q  <= req_size;
      wdata_q <= req_store_word;
    end
  end

  // Select the operands used on the edge that enters RESP.
  always_comb begin
    if (state == IDLE) begin
      acc_addr  = req_address[AW+1:0];
      acc_op    = req_operation;
      acc_size  = req_size;
      acc_wdata = req_store_word;
    end else begin
      acc_addr  = addr_q;
      acc_op    = op_q;
      acc_size  = size_q;
      acc_wdata = wdata_q;
    end
  end

  // Alignment, lane selection and byte enables for the current access.
  always_comb begin
    mis  = 1'b0;
    lane = acc_addr[1:0];
    be   = '1;
    case (acc_size)
      BYTE: begin
        lane = acc_addr[1:0];
        be   = LANES'(4'b0001 << lane);
      end
      HALF: begin
        mis  = acc_addr[0];
        lane = {acc_addr[1], 1'b0};
        be   = LANES'(4'b0011 << lane);
      end
      default: begin
        mis  = |acc_addr[1:0];
        lane = 2'b00;
        be   = '1;
      end
    endcase
  end

  assign idx      = acc_addr[AW+1:2];
  assign wdata_sh = acc_wdata << {lane, 3'b000};
  assign rdata    = mem[idx];
  assign rdata_sh = rdata >> {lane, 3'b000};

  // Right-align and zero-extend the loaded lanes.
  always_comb begin
    case (acc_size)
      BYTE:    rdata_fmt = {{(XLEN-8){1'b0}}, rdata_sh[7:0]};
      HALF:    rdata_fmt = {{(XLEN-16){1'b0}}, rdata_sh[15:0]};
      default: rdata_fmt = rdata;
    endcase
  end

  // A reset on the same edge cancels the access, so an aborted store never lands.
  assign access      = reset_n && (state_next == RESP);
  assign write_en    = access && (acc_op == STORE) && !(TRAP_EN && mis);
  assign load_result = (acc_op == LOAD && !(TRAP_EN && mis)) ? rdata_fmt : '0;

  // Byte-enabled write of the addressed lanes; contents survive reset.
  always_ff @(posedge clk) begin
    if (write_en) begin
      for (int b = 0; b < LANES; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  // Load result register; holds outside the access edge, zero on stores.
  always_ff @(posedge clk) begin
    if (!reset_n)    req_loaded_word <= '0;
    else if (access) req_loaded_word <= load_result;
  end

  assign req_fulfilled = (state == RESP);

`ifdef MAIN_MEMORY_MISALIGN_TRAP_EN
  logic mis_q;

  // Remember whether the serviced request was misaligned for the RESP cycle.
  always_ff @(posedge clk) begin
    if (access) mis_q <= mis;
  end

  assign req_misaligned = (state == RESP) && mis_q;
`endif

endmodule

// File: tb/tb_main_memory.sv
// Scoreboard bench for main_memory: a LATENCY=4 instance for function and
// timing, and a LATENCY=1 instance for back-to-back throughput.
module tb_main_memory;
  import main_memory_pkg::*;

  localparam int LAT = 4;
`ifdef MAIN_MEMORY_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // LATENCY=4 instance
  logic [31:0]            req_address;
  memory_operation_e      req_operation;
  memory_operation_size_e req_size;
  logic [31:0]            req_store_word;
  logic                   req_valid;
  logic [31:0]            req_loaded_word;
  logic                   req_fulfilled;
  logic                   req_misaligned;

  // LATENCY=1 instance
  logic [31:0]            d1_address;
  memory_operation_e      d1_operation;
  memory_operation_size_e d1_size;
  logic [31:0]            d1_store_word;
  logic                   d1_valid;
  logic [31:0]            d1_loaded_word;
  logic                   d1_fulfilled;
  logic                   d1_misaligned;

  main_memory #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_address(req_address), .req_operation(req_operation),
    .req_size(req_size), .req_store_word(req_store_word),
    .req_valid(req_valid), .req_loaded_word(req_loaded_word),
`ifdef MAIN_MEMORY_MISALIGN_TRAP_EN
    .req_misaligned(req_misaligned),
`endif
    .req_fulfilled(req_fulfilled)
  );

  main_memory #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .req_address(d1_address), .req_operation(d1_operation),
    .req_size(d1_size), .req_store_word(d1_store_word),
    .req_valid(d1_valid), .req_loaded_word(d1_loaded_word),
`ifdef MAIN_MEMORY_MISALIGN_TRAP_EN
    .req_misaligned(d1_misaligned),
`endif
    .req_fulfilled(d1_fulfilled)
  );

`ifndef MAIN_MEMORY_MISALIGN_TRAP_EN
  assign req_misaligned = 1'b0;
  assign d1_misaligned  = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endfunction

  typedef struct {
    string       nm;
    logic [31:0] data;
    logic        mis;
    int          t;
  } exp_t;

  exp_t q[$];
  exp_t q1[$];

  // Monitor for the LATENCY=4 instance.
  logic prev_ful = 1'b0;
  always @(negedge clk) begin
    if (req_fulfilled) begin
      chk("ful_not_consecutive", {31'b0, prev_ful}, 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_fulfilled", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.nm, "_data"}, req_loaded_word, e.data);
        chk({e.nm, "_latency_cycle"}, cyc, e.t);
`ifdef MAIN_MEMORY_MISALIGN_TRAP_EN
        chk({e.nm, "_misaligned"}, {31'b0, req_misaligned}, {31'b0, e.mis});
`endif
      end
    end
    prev_ful = req_fulfilled;
  end

  // Monitor for the LATENCY=1 instance.
  int last1  = -1;
  int pulse1 = 0;
  always @(negedge clk) begin
    if (d1_fulfilled) begin
      pulse1++;
      if (last1 >= 0) chk("l1_pulse_spacing", cyc - last1, 32'd2);
      last1 = cyc;
      if (q1.size() == 0) begin
        chk("l1_unexpected_fulfilled", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk({e.nm, "_data"}, d1_loaded_word, e.data);
      end
    end
  end

  // One request on the LATENCY=4 instance. Inputs are scrambled after
  // acceptance. With abort set, reset is pulsed during WAIT instead of
  // waiting for completion.
  task automatic issue(input string nm, input memory_operation_e op,
                       input memory_operation_size_e sz, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_d,
                       input logic exp_m, input bit abort);
    exp_t e;
    int k;
    @(negedge clk);
    req_address    = addr;
    req_operation  = op;
    req_size       = sz;
    req_store_word = wd;
    req_valid      = 1'b1;
    if (!abort) begin
      e.nm = nm; e.data = exp_d; e.mis = exp_m; e.t = cyc + LAT;
      q.push_back(e);
    end
    @(negedge clk);
    req_address    = addr ^ 32'h0000_003C;
    req_store_word = ~wd;
    req_operation  = (op == LOAD) ? STORE : LOAD;
    if (abort) begin
      @(negedge clk);
      reset_n   = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk({nm, "_ful_after_reset"}, {31'b0, req_fulfilled}, 32'd0);
      chk({nm, "_word_after_reset"}, req_loaded_word, 32'd0);
      repeat (LAT + 2) @(negedge clk);
    end else begin
      k = 0;
      while (!req_fulfilled && k < 20) begin
        @(negedge clk);
        k++;
      end
      req_valid = 1'b0;
      if (!req_fulfilled) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s_timeout: req_fulfilled not seen within 20 cycles", nm);
      end
    end
  endtask

  // Present one request on the LATENCY=1 instance (valid stays high).
  task automatic put1(input string nm, input memory_operation_e op,
                      input memory_operation_size_e sz, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_d);
    exp_t e;
    d1_address = addr; d1_operation = op; d1_size = sz; d1_store_word = wd;
    d1_valid = 1'b1;
    e.nm = nm; e.data = exp_d; e.mis = 1'b0; e.t = 0;
    q1.push_back(e);
  endtask

  // Wait (bounded) for a LATENCY=1 completion at a negedge.
  task automatic wait1(input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!d1_fulfilled && k < 10);
    if (!d1_fulfilled) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: req_fulfilled not seen within 10 cycles", nm);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = 1'b0; req_address = '0; req_operation = LOAD;
    req_size = WORD; req_store_word = '0;
    d1_valid = 1'b0; d1_address = '0; d1_operation = LOAD;
    d1_size = WORD; d1_store_word = '0;
    repeat (3) @(negedge clk);
    chk("reset_fulfilled", {31'b0, req_fulfilled}, 32'd0);
    chk("reset_loaded_word", req_loaded_word, 32'd0);
    chk("reset_misaligned", {31'b0, req_misaligned}, 32'd0);
    chk("l1_reset_fulfilled", {31'b0, d1_fulfilled}, 32'd0);
    reset_n = 1'b1;

    // Back-to-back on LATENCY=1 with valid held across completion.
    @(negedge clk);
    put1("l1_st_word", STORE, WORD, 32'h40, 32'hA5A5_A5A5, 32'h0);
    wait1("l1_st_word");
    put1("l1_st_byte", STORE, BYTE, 32'h41, 32'hFFFF_FF3C, 32'h0);
    wait1("l1_st_byte");
    put1("l1_ld_word", LOAD, WORD, 32'h40, 32'h0, 32'hA5A5_3CA5);
    wait1("l1_ld_word");
    put1("l1_ld_half", LOAD, HALF, 32'h42, 32'h0, 32'h0000_A5A5);
    wait1("l1_ld_half");
    d1_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("l1_pulse_count", pulse1, 32'd4);

    // Word store/load, misalignment, byte-lane merge, wrap.
    issue("st_word_10", STORE, WORD, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    issue("ld_word_10", LOAD, WORD, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    issue("ld_word_11", LOAD, WORD, 32'h11, 32'h0,
          TRAP ? 32'h0 : 32'hDEAD_BEEF, TRAP, 1'b0);
    issue("ld_half_11", LOAD, HALF, 32'h11, 32'h0,
          TRAP ? 32'h0 : 32'h0000_BEEF, TRAP, 1'b0);
    issue("st_half_13", STORE, HALF, 32'h13, 32'h0000_FFFF, 32'h0, TRAP, 1'b0);
    issue("ld_after_mis_st", LOAD, WORD, 32'h10, 32'h0,
          TRAP ? 32'hDEAD_BEEF : 32'hFFFF_BEEF, 1'b0, 1'b0);
    issue("st_word_10_again", STORE, WORD, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    issue("st_byte_12", STORE, BYTE, 32'h12, 32'hAAAA_AA5A, 32'h0, 1'b0, 1'b0);
    issue("ld_word_merged", LOAD, WORD, 32'h10, 32'h0, 32'hDE5A_BEEF, 1'b0, 1'b0);
    issue("ld_byte_13", LOAD, BYTE, 32'h13, 32'h0, 32'h0000_00DE, 1'b0, 1'b0);
    issue("ld_half_12", LOAD, HALF, 32'h12, 32'h0, 32'h0000_DE5A, 1'b0, 1'b0);
    issue("ld_byte_10", LOAD, BYTE, 32'h10, 32'h0, 32'h0000_00EF, 1'b0, 1'b0);
    issue("ld_half_10", LOAD, HALF, 32'h10, 32'h0, 32'h0000_BEEF, 1'b0, 1'b0);
    issue("st_word_1004", STORE, WORD, 32'h1004, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    issue("ld_word_0004", LOAD, WORD, 32'h0004, 32'h0, 32'h1234_5678, 1'b0, 1'b0);

    // Reset during WAIT abandons a store.
    issue("st_word_20", STORE, WORD, 32'h20, 32'h1122_3344, 32'h0, 1'b0, 1'b0);
    issue("ld_word_20", LOAD, WORD, 32'h20, 32'h0, 32'h1122_3344, 1'b0, 1'b0);
    issue("aborted_st_20", STORE, WORD, 32'h20, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1);
    issue("ld_after_abort", LOAD, WORD, 32'h20, 32'h0, 32'h1122_3344, 1'b0, 1'b0);

    repeat (8) @(negedge clk);
    chk("scoreboard_empty", q.size(), 32'd0);
    chk("l1_scoreboard_empty", q1.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule
